ol_dpwm_ctrl: RTL and testbench

- Parametrised open-loop DPWM controller: period counter, duty-to-on-time scaling, programmable dead times and a ramped soft start in one block.
- Generates complementary gate drives c1/c2 for the power stage from user duty, period and dead-time settings.
- Adds runtime period programming, period-boundary shadow updates, a periods-per-step soft-start ramp and status outputs.

---
 rtl/ol_dpwm_ctrl.sv | 143 ++++++++++++++
 tb/tb_ol_dpwm_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ol_dpwm_ctrl.sv
// Open-loop DPWM controller: period counter, duty-to-on-time scaling, dead-time
// insertion and a periods-per-step soft-start ramp driving a complementary gate pair.
module ol_dpwm_ctrl #(
    parameter int CNT_W   = 11,
    parameter int DUTY_W  = 8,
    parameter int DT_W    = 5,
    parameter int SS_STEP = 1,
    parameter int SS_PER  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_ss_en,
    input  logic [CNT_W-1:0]  i_period,
    input  logic [DUTY_W-1:0] i_duty,
    input  logic [DT_W-1:0]   i_dt1,
    input  logic [DT_W-1:0]   i_dt2,
    output logic              o_c1,
    output logic              o_c2,
    output logic              o_ss_done,
    output logic              o_period_start
);

    localparam int PROD_W = CNT_W + DUTY_W;
    localparam int PC_W   = (SS_PER > 1) ? $clog2(SS_PER) : 1;

    typedef enum logic [1:0] {IDLE, RAMP, RUN} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  per_q;
    logic [CNT_W-1:0]  ton_q;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] ss_duty;
    logic [DT_W-1:0]   dt1_q;
    logic [DT_W-1:0]   dt2_q;
    logic [PC_W-1:0]   pc;

    logic              active;
    logic              entry;
    logic              boundary;
    logic              load;
    logic              step_hit;
    logic              ramp_done;
    logic              ramp_next;
    logic [CNT_W-1:0]  per_d;
    logic [CNT_W-1:0]  ton_d;
    logic [DUTY_W-1:0] duty_d;
    logic [DUTY_W-1:0] ss_next;
    logic [DUTY_W-1:0] deff_d;
    logic [DUTY_W:0]   ss_sum;
    logic [PROD_W-1:0] prod;
    logic [CNT_W:0]    c2_start;

    // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
    always_comb begin
        active    = (state != IDLE) && i_en;
        entry     = (state == IDLE) && i_en;
        boundary  = active && (cnt == per_q);
        load      = entry || boundary;
        per_d     = load ? i_period : per_q;
        duty_d    = load ? i_duty   : duty_q;
        step_hit  = (pc == PC_W'(SS_PER - 1));
        ss_sum    = {1'b0, ss_duty} + (step_hit ? (DUTY_W+1)'(SS_STEP) : '0);
        ss_next   = ss_duty;
        if (entry)
            ss_next = '0;
        else if (boundary && state == RAMP)
            ss_next = (ss_sum > {1'b0, duty_d}) ? duty_d : ss_sum[DUTY_W-1:0];
        ramp_done = boundary && (state == RAMP) && (ss_next == duty_d);
        ramp_next = entry ? i_ss_en : (active && state == RAMP && !ramp_done);
        deff_d    = ramp_next ? ss_next : duty_d;
        // Scale from the values the shadows are about to hold, so ton_q is already
        // consistent with them on the cnt==0 cycle of a new period.
        prod      = PROD_W'(deff_d) * (PROD_W'(per_d) + PROD_W'(1));
        ton_d     = CNT_W'(prod >> DUTY_W);
        c2_start  = {1'b0, ton_q} + (CNT_W+1)'(dt2_q);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            per_q          <= '0;
            ton_q          <= '0;
            duty_q         <= '0;
            ss_duty        <= '0;
            dt1_q          <= '0;
            dt2_q          <= '0;
            pc             <= '0;
            o_c1           <= 1'b0;
            o_c2           <= 1'b0;
            o_ss_done      <= 1'b0;
            o_period_start <= 1'b0;
        end else begin
            ton_q   <= ton_d;
            ss_duty <= ss_next;
            if (load) begin
                per_q  <= i_period;
                duty_q <= i_duty;
                dt1_q  <= i_dt1;
                dt2_q  <= i_dt2;
            end

            o_c1           <= active && (cnt >= CNT_W'(dt1_q)) && (cnt < ton_q);
            o_c2           <= active && ({1'b0, cnt} >= c2_start) && (cnt <= per_q);
            o_period_start <= active && (cnt == '0);

            case (state)
                IDLE: begin
                    cnt <= '0;
                    pc  <= '0;
                    if (i_en) begin
                        state     <= i_ss_en ? RAMP : RUN;
                        o_ss_done <= !i_ss_en;
                    end
                end
                RAMP, RUN: begin
                    if (!i_en) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        pc        <= '0;
                        o_ss_done <= 1'b0;
                    end else begin
                        cnt <= boundary ? '0 : cnt + CNT_W'(1);
                        if (state == RAMP && boundary)
                            pc <= step_hit ? '0 : pc + PC_W'(1);
                        if (ramp_done) begin
                            state     <= RUN;
                            o_ss_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // c1 ends before ton and c2 starts at or after ton, so the drives can never overlap.
    no_shoot_through: assert property (@(posedge clk) disable iff (!rst) !(o_c1 && o_c2));

endmodule

// File: tb/tb_ol_dpwm_ctrl.sv
// Scoreboard bench for ol_dpwm_ctrl: stimulus queues expected per-period pulse
// shapes; a monitor measures each period between o_period_start pulses and compares.
module tb_ol_dpwm_ctrl;

    localparam int CNT_W   = 11;
    localparam int DUTY_W  = 8;
    localparam int DT_W    = 5;
    localparam int SS_STEP = 1;
    localparam int SS_PER  = 4;

    logic              clk;
    logic              rst;
    logic              i_en;
    logic              i_ss_en;
    logic [CNT_W-1:0]  i_period;
    logic [DUTY_W-1:0] i_duty;
    logic [DT_W-1:0]   i_dt1;
    logic [DT_W-1:0]   i_dt2;
    logic              o_c1;
    logic              o_c2;
    logic              o_ss_done;
    logic              o_period_start;

    ol_dpwm_ctrl #(
        .CNT_W(CNT_W), .DUTY_W(DUTY_W), .DT_W(DT_W), .SS_STEP(SS_STEP), .SS_PER(SS_PER)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_ss_en(i_ss_en),
        .i_period(i_period), .i_duty(i_duty), .i_dt1(i_dt1), .i_dt2(i_dt2),
        .o_c1(o_c1), .o_c2(o_c2), .o_ss_done(o_ss_done), .o_period_start(o_period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shape of one measured period; first-high indices are 0 when the drive never rises.
    typedef struct {
        int len;
        int c1_first;
        int c1_w;
        int c2_first;
        int c2_w;
        int ss;
        int ovl;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rec_no = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input int len, input int c1f, input int c1w,
                                input int c2f, input int c2w, input int ss);
        rec_t r;
        r.len = len; r.c1_first = c1f; r.c1_w = c1w;
        r.c2_first = c2f; r.c2_w = c2w; r.ss = ss; r.ovl = 0;
        return r;
    endfunction

    // Full-period shape for period length p+1, effective duty deff and dead times.
    function automatic rec_t model(input int p, input int deff, input int dt1,
                                   input int dt2, input int ss);
        int ton, c1w, c2s, c2w;
        ton = (deff * (p + 1)) >> DUTY_W;
        c1w = (ton > dt1) ? ton - dt1 : 0;
        c2s = ton + dt2;
        c2w = (c2s <= p) ? p - c2s + 1 : 0;
        return mk(p + 1, (c1w > 0) ? dt1 : 0, c1w, (c2w > 0) ? c2s : 0, c2w, ss);
    endfunction

    task automatic compare(input rec_t act);
        rec_t e;
        rec_no++;
        if (exp_q.size() == 0) begin
            check($sformatf("p%0d_unexpected_period_len", rec_no), act.len, -1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("p%0d_len", rec_no), act.len, e.len);
            check($sformatf("p%0d_c1_first", rec_no), act.c1_first, e.c1_first);
            check($sformatf("p%0d_c1_width", rec_no), act.c1_w, e.c1_w);
            check($sformatf("p%0d_c2_first", rec_no), act.c2_first, e.c2_first);
            check($sformatf("p%0d_c2_width", rec_no), act.c2_w, e.c2_w);
            check($sformatf("p%0d_ss_done", rec_no), act.ss, e.ss);
            check($sformatf("p%0d_overlap", rec_no), act.ovl, e.ovl);
        end
    endtask

    // Monitor: one record per span between period_start pulses.
    rec_t cur;
    bit   have = 1'b0;
    int   idx  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (o_period_start === 1'b1) begin
                if (have) compare(cur);
                cur = mk(0, 0, 0, 0, 0, 0);
                cur.ss = int'(o_ss_done);
                have = 1'b1;
                idx = 0;
            end
            if (have) begin
                if (o_c1 === 1'b1) begin
                    if (cur.c1_w == 0) cur.c1_first = idx;
                    cur.c1_w++;
                end
                if (o_c2 === 1'b1) begin
                    if (cur.c2_w == 0) cur.c2_first = idx;
                    cur.c2_w++;
                end
                if (o_c1 === 1'b1 && o_c2 === 1'b1) cur.ovl++;
                cur.len++;
                idx++;
            end
        end
    end

    task automatic wait_ps();
        int seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (o_period_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("period_start_seen", seen, 1);
    endtask

    initial begin
        rst = 1'b0; i_en = 1'b1; i_ss_en = 1'b0;
        i_period = 11'd99; i_duty = 8'd128; i_dt1 = 5'd3; i_dt2 = 5'd4;

        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", int'({o_c1, o_c2, o_ss_done, o_period_start}), 0);
        end

        // Open-loop run: D=128 (ton 50), then D=64 (ton 25), D=0, then P=255 D=255 dt2=5.
        repeat (3) exp_q.push_back(mk(100, 3, 47, 54, 46, 1));
        exp_q.push_back(mk(100, 3, 22, 29, 71, 1));
        exp_q.push_back(mk(100, 0, 0, 4, 96, 1));
        exp_q.push_back(mk(256, 3, 252, 0, 0, 1));
        exp_q.push_back(mk(7, 0, 0, 0, 0, 1));        // cut off after its cnt==0 cycle
        rst = 1'b1;

        wait_ps(); wait_ps(); wait_ps();
        repeat (19) @(negedge clk);
        i_duty = 8'd64;
        wait_ps();
        repeat (19) @(negedge clk);
        i_duty = 8'd0;
        wait_ps();
        repeat (19) @(negedge clk);
        i_period = 11'd255; i_duty = 8'd255; i_dt2 = 5'd5;
        wait_ps();
        wait_ps();
        i_en = 1'b0;
        @(negedge clk);
        check("disable_outputs_run", int'({o_c1, o_c2, o_ss_done, o_period_start}), 0);
        repeat (4) @(negedge clk);

        // Soft start D=8, dropped at cnt=60 of period 14 (ss_duty=3, ton=1).
        for (int n = 1; n <= 13; n++)
            exp_q.push_back(model(99, ((n - 1) / SS_PER > 8) ? 8 : (n - 1) / SS_PER, 0, 4, 0));
        exp_q.push_back(mk(66, 0, 1, 5, 55, 0));
        i_ss_en = 1'b1; i_period = 11'd99; i_duty = 8'd8; i_dt1 = 5'd0; i_dt2 = 5'd4;
        i_en = 1'b1;
        repeat (14) wait_ps();
        repeat (59) @(negedge clk);
        i_en = 1'b0;
        @(negedge clk);
        check("disable_outputs_ramp", int'({o_c1, o_c2, o_ss_done, o_period_start}), 0);
        repeat (4) @(negedge clk);

        // Re-enable: ramp restarts from zero and completes after 32 periods.
        for (int n = 1; n <= 34; n++)
            exp_q.push_back(model(99, ((n - 1) / SS_PER > 8) ? 8 : (n - 1) / SS_PER, 0, 4,
                                  (n >= 33) ? 1 : 0));
        i_en = 1'b1;
        repeat (35) wait_ps();
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
